// File: rtl/display_slot_scheduler_pkg.sv
// display_pkg: shared definitions for the display slot scheduler.
//   - FSM state encoding
//   - default VGA / slot counter widths
//   - default slot lengths for the map and character renderers
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int DEF_X_W       = 8;
  localparam int DEF_Y_W       = 8;
  localparam int DEF_COLOR_W   = 3;
  localparam int DEF_SLOT_W    = 15;

  localparam int MAP_SLOT_LEN  = 11025;
  localparam int CHAR_SLOT_LEN = 101;

endpackage

// File: rtl/display_slot_scheduler_if.sv
// display_slot_scheduler_if: bundle of the per-source plot streams, the
// run enable, the grant/start controls and the shared VGA plot port.
//   master : the scheduler (consumes source streams, drives grants and VGA)
//   slave  : the environment (sources, game logic, VGA adapter)
interface display_slot_scheduler_if #(
  parameter int N_SRC   = 2,
  parameter int X_W     = 8,
  parameter int Y_W     = 8,
  parameter int COLOR_W = 3
);
  logic                     en;
  logic [N_SRC-1:0]         src_plot;
  logic [N_SRC*X_W-1:0]     src_x;
  logic [N_SRC*Y_W-1:0]     src_y;
  logic [N_SRC*COLOR_W-1:0] src_color;
  logic [N_SRC-1:0]         src_done;
  logic [N_SRC-1:0]         src_grant;
  logic [N_SRC-1:0]         src_start;
  logic                     vga_plot;
  logic [X_W-1:0]           vga_x;
  logic [Y_W-1:0]           vga_y;
  logic [COLOR_W-1:0]       vga_color;
  logic                     is_display_running;
  logic                     frame_done;

  modport master (
    input  en, src_plot, src_x, src_y, src_color, src_done,
    output src_grant, src_start, vga_plot, vga_x, vga_y, vga_color,
           is_display_running, frame_done
  );

  modport slave (
    output en, src_plot, src_x, src_y, src_color, src_done,
    input  src_grant, src_start, vga_plot, vga_x, vga_y, vga_color,
           is_display_running, frame_done
  );
endinterface

// File: rtl/display_slot_scheduler_timer.sv
// display_slot_timer: per-slot cycle counter and end-of-slot detection.
// Ports:
//   clock_50, reset : clock and synchronous active-high reset
//   run             : scheduler is in RUN; counter is held at 0 otherwise
//   idx             : index of the slot currently being timed
//   src_done        : per-source "work finished" levels
//   slot_end        : current cycle is the last one of slot idx
// Optional feature: DISPLAY_SCHED_EARLY_ADVANCE_EN lets src_done[idx] end
// the slot early; without it src_done is ignored.
module display_slot_timer #(
  parameter int                      N_SRC     = 2,
  parameter int                      SLOT_W    = 15,
  parameter int                      IDX_W     = 1,
  parameter logic [N_SRC*SLOT_W-1:0] SLOT_LENS = '0
)(
  input  logic             clock_50,
  input  logic             reset,
  input  logic             run,
  input  logic [IDX_W-1:0] idx,
  input  logic [N_SRC-1:0] src_done,
  output logic             slot_end
);

  logic [SLOT_W-1:0] cnt;
  logic [SLOT_W-1:0] len;
  logic [SLOT_W-1:0] last_cnt;
  logic              len_hit;

  assign len      = SLOT_LENS[idx*SLOT_W +: SLOT_W];
  // A zero length behaves as a one-cycle slot.
  assign last_cnt = (len == '0) ? '0 : len - 1'b1;
  assign len_hit  = (cnt == last_cnt);

`ifdef DISPLAY_SCHED_EARLY_ADVANCE_EN
  // Either condition ends the slot; both together still give one advance.
  assign slot_end = run && (len_hit || src_done[idx]);
`else
  logic unused_src_done;
  assign unused_src_done = ^src_done;
  assign slot_end        = run && len_hit;
`endif

  // Counter restarts at 0 on every new slot and whenever not running,
  // so entry into RUN always begins at cnt=0.
  always_ff @(posedge clock_50) begin
    if (reset || !run || slot_end) cnt <= '0;
    else                           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/display_slot_scheduler.sv
// display_slot_scheduler: time-slices one VGA plot port among N_SRC display
// sources. Each source owns a fixed-length slot per frame, in index order,
// followed by GAP_CYCLES idle cycles. The granted source's pixel stream is
// registered onto the VGA port with one cycle of latency.
// Ports:
//   clock_50, reset : clock and synchronous active-high reset
//   bus (master)    : en, src_plot/x/y/color/done in;
//                     src_grant, src_start, vga_plot/x/y/color,
//                     is_display_running, frame_done out
// Optional feature: DISPLAY_SCHED_EARLY_ADVANCE_EN (see display_slot_timer).
module display_slot_scheduler
  import display_pkg::*;
#(
  parameter int                      N_SRC      = 2,
  parameter int                      X_W        = DEF_X_W,
  parameter int                      Y_W        = DEF_Y_W,
  parameter int                      COLOR_W    = DEF_COLOR_W,
  parameter int                      SLOT_W     = DEF_SLOT_W,
  parameter logic [N_SRC*SLOT_W-1:0] SLOT_LENS  = {SLOT_W'(CHAR_SLOT_LEN),
                                                   SLOT_W'(MAP_SLOT_LEN)},
  parameter int                      GAP_CYCLES = 1
)(
  input  logic                      clock_50,
  input  logic                      reset,
  display_slot_scheduler_if.master  bus
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SRC - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);

  function automatic logic [N_SRC-1:0] onehot(input logic [IDX_W-1:0] i);
    return N_SRC'(1) << i;
  endfunction

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [GAP_W-1:0]   gap_cnt;
  logic               slot_end;
  logic [N_SRC-1:0]   grant_r;
  logic [N_SRC-1:0]   start_r;
  logic               running_r;
  logic               frame_done_r;
  logic               vga_plot_r;
  logic [X_W-1:0]     vga_x_r;
  logic [Y_W-1:0]     vga_y_r;
  logic [COLOR_W-1:0] vga_color_r;

  display_slot_timer #(
    .N_SRC     (N_SRC),
    .SLOT_W    (SLOT_W),
    .IDX_W     (IDX_W),
    .SLOT_LENS (SLOT_LENS)
  ) u_timer (
    .clock_50 (clock_50),
    .reset    (reset),
    .run      (state == ST_RUN),
    .idx      (idx),
    .src_done (bus.src_done),
    .slot_end (slot_end)
  );

  // Grant/start/running/frame_done are set together with the transition
  // that creates them, so they line up exactly with the state they describe.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      state        <= ST_IDLE;
      idx          <= '0;
      gap_cnt      <= '0;
      grant_r      <= '0;
      start_r      <= '0;
      running_r    <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      start_r      <= '0;
      frame_done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.en) begin
            state     <= ST_RUN;
            idx       <= '0;
            grant_r   <= onehot('0);
            start_r   <= onehot('0);
            running_r <= 1'b1;
          end
        end
        ST_RUN: begin
          if (slot_end) begin
            if (idx != LAST_IDX) begin
              idx     <= idx + 1'b1;
              grant_r <= onehot(idx + 1'b1);
              start_r <= onehot(idx + 1'b1);
            end else begin
              state        <= ST_GAP;
              gap_cnt      <= '0;
              grant_r      <= '0;
              running_r    <= 1'b0;
              frame_done_r <= (GAP_CYCLES == 1);
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == LAST_GAP) begin
            // en is only honoured here, so a dropped en lets the frame finish.
            if (bus.en) begin
              state     <= ST_RUN;
              idx       <= '0;
              grant_r   <= onehot('0);
              start_r   <= onehot('0);
              running_r <= 1'b1;
            end else begin
              state <= ST_IDLE;
              idx   <= '0;
            end
          end else begin
            gap_cnt      <= gap_cnt + 1'b1;
            frame_done_r <= (gap_cnt + 1'b1 == LAST_GAP);
          end
        end
        default: begin
          state     <= ST_IDLE;
          idx       <= '0;
          grant_r   <= '0;
          running_r <= 1'b0;
        end
      endcase
    end
  end

  // Output stage: one register between the granted source and the VGA port.
  always_ff @(posedge clock_50) begin
    if (reset || state != ST_RUN) begin
      vga_plot_r  <= 1'b0;
      vga_x_r     <= '0;
      vga_y_r     <= '0;
      vga_color_r <= '0;
    end else begin
      vga_plot_r  <= bus.src_plot[idx];
      vga_x_r     <= bus.src_x[idx*X_W +: X_W];
      vga_y_r     <= bus.src_y[idx*Y_W +: Y_W];
      vga_color_r <= bus.src_color[idx*COLOR_W +: COLOR_W];
    end
  end

  assign bus.src_grant          = grant_r;
  assign bus.src_start          = start_r;
  assign bus.is_display_running = running_r;
  assign bus.frame_done         = frame_done_r;
  assign bus.vga_plot           = vga_plot_r;
  assign bus.vga_x              = vga_x_r;
  assign bus.vga_y              = vga_y_r;
  assign bus.vga_color          = vga_color_r;

endmodule

// File: tb/tb_display_slot_scheduler.sv
// Testbench for display_slot_scheduler with default parameters
// (slot 0 = 11025 cycles, slot 1 = 101 cycles, 1 gap cycle).
// k counts rising edges since the last reset release; outputs are sampled
// on the falling edge after edge k and inputs change right after sampling.
module tb_display_slot_scheduler;

  logic clock_50 = 1'b0;
  logic reset;
  int   kcnt;
  int   n_checks = 0;
  int   n_errors = 0;

  always #10 clock_50 = ~clock_50;

  display_slot_scheduler_if #(.N_SRC(2), .X_W(8), .Y_W(8), .COLOR_W(3)) bus ();

  display_slot_scheduler dut (
    .clock_50 (clock_50),
    .reset    (reset),
    .bus      (bus)
  );

  typedef struct {
    int         k;
    logic [1:0] grant;
    logic [1:0] start;
    logic       run;
    logic       fd;
    logic       vp;
    logic [7:0] vx;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, kcnt);
    end
  endtask

  task automatic tick();
    @(posedge clock_50);
    kcnt++;
    @(negedge clock_50);
  endtask

  task automatic adv_to(input int k);
    while (kcnt < k) tick();
  endtask

  // y and colour are tied to x by the stimulus: source 0 = (10,3,2),
  // source 1 = (40,7,5), idle = (0,0,0).
  task automatic chk_vec(input vec_t v);
    logic [7:0] ey;
    logic [2:0] ec;
    ey = (v.vx == 8'd10) ? 8'd3 : (v.vx == 8'd40) ? 8'd7 : 8'd0;
    ec = (v.vx == 8'd10) ? 3'd2 : (v.vx == 8'd40) ? 3'd5 : 3'd0;
    chk($sformatf("k%0d grant", v.k),   32'(bus.src_grant),          32'(v.grant));
    chk($sformatf("k%0d start", v.k),   32'(bus.src_start),          32'(v.start));
    chk($sformatf("k%0d running", v.k), 32'(bus.is_display_running), 32'(v.run));
    chk($sformatf("k%0d frame_done", v.k), 32'(bus.frame_done),      32'(v.fd));
    chk($sformatf("k%0d vga_plot", v.k), 32'(bus.vga_plot),          32'(v.vp));
    chk($sformatf("k%0d vga_x", v.k),   32'(bus.vga_x),              32'(v.vx));
    chk($sformatf("k%0d vga_y", v.k),   32'(bus.vga_y),              32'(ey));
    chk($sformatf("k%0d vga_color", v.k), 32'(bus.vga_color),        32'(ec));
  endtask

  function automatic vec_t mk(input int k, input logic [1:0] g, input logic [1:0] s,
                              input logic r, input logic f, input logic p,
                              input logic [7:0] x);
    vec_t v;
    v.k = k; v.grant = g; v.start = s; v.run = r; v.fd = f; v.vp = p; v.vx = x;
    return v;
  endfunction

  initial begin
    // First frame: slot 0 on edges 1..11025, slot 1 on 11026..11126,
    // gap on 11127, second frame starts on 11128.
    vecs[0] = mk(1,     2'b01, 2'b01, 1, 0, 0, 8'd0);
    vecs[1] = mk(2,     2'b01, 2'b00, 1, 0, 1, 8'd10);
    vecs[2] = mk(500,   2'b01, 2'b00, 1, 0, 1, 8'd10);
    vecs[3] = mk(11025, 2'b01, 2'b00, 1, 0, 1, 8'd10);
    vecs[4] = mk(11026, 2'b10, 2'b10, 1, 0, 1, 8'd10);
    vecs[5] = mk(11027, 2'b10, 2'b00, 1, 0, 1, 8'd40);
    vecs[6] = mk(11126, 2'b10, 2'b00, 1, 0, 1, 8'd40);
    vecs[7] = mk(11127, 2'b00, 2'b00, 0, 1, 1, 8'd40);
    vecs[8] = mk(11128, 2'b01, 2'b01, 1, 0, 0, 8'd0);
    vecs[9] = mk(11129, 2'b01, 2'b00, 1, 0, 1, 8'd10);

    reset         = 1'b1;
    kcnt          = 0;
    bus.en        = 1'b1;
    bus.src_plot  = 2'b11;
    bus.src_x     = {8'd40, 8'd10};
    bus.src_y     = {8'd7, 8'd3};
    bus.src_color = {3'd5, 3'd2};
    bus.src_done  = 2'b00;

    // Reset held with en=1: everything stays at 0.
    @(negedge clock_50);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_vec(mk(0, 2'b00, 2'b00, 0, 0, 0, 8'd0));
    end
    reset = 1'b0;
    kcnt  = 0;

    for (int i = 0; i < 10; i++) begin
      adv_to(vecs[i].k);
      chk_vec(vecs[i]);
    end

    // Second frame (slot 0 from 11128): en dropped at slot cycle 500.
    adv_to(11628);
    bus.en = 1'b0;
    // Slot 1 runs 22153..22253; a non-granted source's plot is never emitted.
    adv_to(22160);
    bus.src_plot = 2'b01;
    tick();
    chk("nongrant vga_plot", 32'(bus.vga_plot), 32'd0);
    chk("nongrant vga_x",    32'(bus.vga_x),    32'd40);
    // Plot presented only in the last slot cycle still comes out in the gap.
    adv_to(22253);
    chk("last slot grant", 32'(bus.src_grant), 32'b10);
    bus.src_plot = 2'b10;
    tick();
    chk_vec(mk(22254, 2'b00, 2'b00, 0, 1, 1, 8'd40));
    bus.src_plot = 2'b11;
    tick();
    chk_vec(mk(22255, 2'b00, 2'b00, 0, 0, 0, 8'd0));
    adv_to(22260);
    chk_vec(mk(22260, 2'b00, 2'b00, 0, 0, 0, 8'd0));

    // Restart from IDLE.
    bus.en = 1'b1;
    tick();
    chk_vec(mk(22261, 2'b01, 2'b01, 1, 0, 0, 8'd0));
    // Slot 1 begins at 22261+11025 = 33286; reset in the middle of it.
    adv_to(33286);
    chk("slot1 start", 32'(bus.src_start), 32'b10);
    adv_to(33300);
    reset = 1'b1;
    tick();
    chk_vec(mk(33301, 2'b00, 2'b00, 0, 0, 0, 8'd0));
    reset = 1'b0;
    tick();
    chk_vec(mk(33302, 2'b01, 2'b01, 1, 0, 0, 8'd0));
    tick();
    chk_vec(mk(33303, 2'b01, 2'b00, 1, 0, 1, 8'd10));

    // src_done[0] while slot 0 is at cnt=20 (edge 33322).
    adv_to(33322);
    bus.src_done = 2'b01;
    tick();
`ifdef DISPLAY_SCHED_EARLY_ADVANCE_EN
    chk_vec(mk(33323, 2'b10, 2'b10, 1, 0, 1, 8'd10));
`else
    chk_vec(mk(33323, 2'b01, 2'b00, 1, 0, 1, 8'd10));
`endif
    bus.src_done = 2'b00;
    tick();
`ifdef DISPLAY_SCHED_EARLY_ADVANCE_EN
    chk_vec(mk(33324, 2'b10, 2'b00, 1, 0, 1, 8'd40));
`else
    chk_vec(mk(33324, 2'b01, 2'b00, 1, 0, 1, 8'd10));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
